// File: rtl/mbinit_pkg.sv
// Shared definitions for the MBINIT stages: sideband message codes, the
// REVERSALMB state encoding and the default lane count.
package mbinit_pkg;

    localparam int NUM_LANES_DEF = 16;

    localparam logic [3:0] MSG_NONE           = 4'd0;
    localparam logic [3:0] MSG_INIT_REQ       = 4'd1;
    localparam logic [3:0] MSG_INIT_RESP      = 4'd2;
    localparam logic [3:0] MSG_CLEAR_ERR_REQ  = 4'd3;
    localparam logic [3:0] MSG_CLEAR_ERR_RESP = 4'd4;
    localparam logic [3:0] MSG_RESULT_REQ     = 4'd5;
    localparam logic [3:0] MSG_RESULT_RESP    = 4'd6;
    localparam logic [3:0] MSG_DONE_REQ       = 4'd7;
    localparam logic [3:0] MSG_DONE_RESP      = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_REQ,
        ST_WAIT_INIT,
        ST_CHK_CLR,
        ST_CLR_REQ,
        ST_WAIT_CLR,
        ST_PATTERN,
        ST_CHK_RES,
        ST_RESULT_REQ,
        ST_WAIT_RES,
        ST_EVAL,
        ST_CHK_DONE,
        ST_DONE_REQ,
        ST_WAIT_DONE,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Request code a *_REQ state sends; MSG_NONE for every other state.
    function automatic logic [3:0] req_msg(input state_t s);
        case (s)
            ST_INIT_REQ:   return MSG_INIT_REQ;
            ST_CLR_REQ:    return MSG_CLEAR_ERR_REQ;
            ST_RESULT_REQ: return MSG_RESULT_REQ;
            ST_DONE_REQ:   return MSG_DONE_REQ;
            default:       return MSG_NONE;
        endcase
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_INIT) || (s == ST_WAIT_CLR) ||
               (s == ST_WAIT_RES)  || (s == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/lane_popcount.sv
// Counts the passing lanes of a result vector; the count is registered when
// i_load is high so it is stable for the evaluation cycle that follows.
module lane_popcount
    import mbinit_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [NUM_LANES-1:0] i_bits,
    output logic [CNT_W-1:0]     o_count
);

    logic [CNT_W-1:0] w_ones;
    logic [CNT_W-1:0] r_count;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_ones = w_ones + CNT_W'(i_bits[i]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= w_ones;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/reversalmb_module.sv
// MBINIT.REVERSALMB: sideband handshake, lane-result evaluation and a single
// lane-reversal retry. Define REVERSALMB_TIMEOUT_EN to bound every WAIT_* state.
module reversalmb_module
    import mbinit_pkg::*;
#(
    parameter int NUM_LANES      = NUM_LANES_DEF,
    parameter int PASS_THRESHOLD = 8,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 i_MBINIT_REPAIRVAL_end,
    input  logic [3:0]           i_RX_SbMessage,
    input  logic                 i_msg_valid,
    input  logic                 i_Busy_SideBand,
    input  logic                 i_falling_edge_busy,
    input  logic [NUM_LANES-1:0] i_rx_lane_result,
    input  logic                 i_pattern_done,
    output logic [3:0]           o_TX_SbMessage,
    output logic                 o_ValidOutDatat_REVERSALMB,
    output logic                 o_pattern_en,
    output logic                 o_lane_reversal,
    output logic                 o_MBINIT_REVERSALMB_end,
    output logic                 o_train_error
);

    localparam int CNT_W = $clog2(NUM_LANES + 1);
    localparam logic [CNT_W-1:0] PASS_THR = CNT_W'(PASS_THRESHOLD);

    state_t           r_cs;
    state_t           w_ns;
    logic             r_retry;
    logic [3:0]       r_tx_msg;
    logic             r_tx_valid;
    logic             r_pattern_en;
    logic             r_lane_reversal;
    logic             r_end;
    logic             r_error;
    logic             w_en;
    logic [3:0]       w_msg;
    logic             w_capture;
    logic             w_timeout;
    logic             w_enter;
    logic [CNT_W-1:0] w_pass_cnt;

    assign w_en      = i_MBINIT_REPAIRVAL_end;
    assign w_msg     = i_msg_valid ? i_RX_SbMessage : MSG_NONE;
    assign w_enter   = (w_ns != r_cs);
    assign w_capture = w_en && (r_cs == ST_WAIT_RES) && (w_msg == MSG_RESULT_RESP);

    lane_popcount #(
        .NUM_LANES (NUM_LANES),
        .CNT_W     (CNT_W)
    ) u_popcount (
        .i_clk   (CLK),
        .i_rst   (rst),
        .i_load  (w_capture),
        .i_bits  (i_rx_lane_result),
        .o_count (w_pass_cnt)
    );

`ifdef REVERSALMB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_enter || !is_wait(r_cs)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = is_wait(r_cs) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled: WAIT_* states wait indefinitely.
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES < 1);
`endif

    always_comb begin
        w_ns = r_cs;
        if (r_cs != ST_IDLE && !w_en) begin
            w_ns = ST_IDLE;
        end else begin
            case (r_cs)
                ST_IDLE:       if (w_en && !i_Busy_SideBand) w_ns = ST_INIT_REQ;
                ST_INIT_REQ:   if (i_falling_edge_busy) w_ns = ST_WAIT_INIT;
                ST_WAIT_INIT:  if (w_timeout) w_ns = ST_ERROR;
                               else if (w_msg == MSG_INIT_RESP) w_ns = ST_CHK_CLR;
                ST_CHK_CLR:    if (!i_Busy_SideBand) w_ns = ST_CLR_REQ;
                ST_CLR_REQ:    if (i_falling_edge_busy) w_ns = ST_WAIT_CLR;
                ST_WAIT_CLR:   if (w_timeout) w_ns = ST_ERROR;
                               else if (w_msg == MSG_CLEAR_ERR_RESP) w_ns = ST_PATTERN;
                ST_PATTERN:    if (i_pattern_done) w_ns = ST_CHK_RES;
                ST_CHK_RES:    if (!i_Busy_SideBand) w_ns = ST_RESULT_REQ;
                ST_RESULT_REQ: if (i_falling_edge_busy) w_ns = ST_WAIT_RES;
                ST_WAIT_RES:   if (w_timeout) w_ns = ST_ERROR;
                               else if (w_msg == MSG_RESULT_RESP) w_ns = ST_EVAL;
                ST_EVAL:       if (w_pass_cnt > PASS_THR) w_ns = ST_CHK_DONE;
                               else if (!r_retry) w_ns = ST_CHK_CLR;
                               else w_ns = ST_ERROR;
                ST_CHK_DONE:   if (!i_Busy_SideBand) w_ns = ST_DONE_REQ;
                ST_DONE_REQ:   if (i_falling_edge_busy) w_ns = ST_WAIT_DONE;
                ST_WAIT_DONE:  if (w_timeout) w_ns = ST_ERROR;
                               else if (w_msg == MSG_DONE_RESP) w_ns = ST_DONE;
                default:       w_ns = r_cs;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_cs            <= ST_IDLE;
            r_retry         <= 1'b0;
            r_tx_msg        <= MSG_NONE;
            r_tx_valid      <= 1'b0;
            r_pattern_en    <= 1'b0;
            r_lane_reversal <= 1'b0;
            r_end           <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_cs         <= w_ns;
            r_tx_valid   <= w_enter && (req_msg(w_ns) != MSG_NONE);
            r_tx_msg     <= w_enter ? req_msg(w_ns) : MSG_NONE;
            r_pattern_en <= (w_ns == ST_PATTERN);
            r_end        <= (w_ns == ST_DONE);
            r_error      <= (w_ns == ST_ERROR);
            if (w_enter && w_ns == ST_INIT_REQ) begin
                r_lane_reversal <= 1'b0;
                r_retry         <= 1'b0;
            end else if (r_cs == ST_EVAL && w_ns == ST_CHK_CLR) begin
                r_lane_reversal <= 1'b1;
                r_retry         <= 1'b1;
            end
        end
    end

    assign o_TX_SbMessage             = r_tx_msg;
    assign o_ValidOutDatat_REVERSALMB = r_tx_valid;
    assign o_pattern_en               = r_pattern_en;
    assign o_lane_reversal            = r_lane_reversal;
    assign o_MBINIT_REVERSALMB_end    = r_end;
    assign o_train_error              = r_error;

endmodule
